// File: rtl/kf_pkg.sv
// Shared encodings for the Kalman-filter microprogram sequencer: opcodes,
// destinations, instruction field positions and FSM states.
package kf_pkg;

    localparam int KF_ADDRW   = 5;
    localparam int KF_PCW     = 8;
    localparam int KF_FNW     = 3;
    localparam int KF_INSTW   = 3 + 2 + KF_ADDRW + KF_ADDRW + KF_FNW;
    localparam int KF_MAXWAIT = 64;

    // Field LSB positions, packed {op, dst, dira, dirb, fn} from MSB down.
    localparam int F_FN_LO  = 0;
    localparam int F_B_LO   = F_FN_LO + KF_FNW;
    localparam int F_A_LO   = F_B_LO + KF_ADDRW;
    localparam int F_DST_LO = F_A_LO + KF_ADDRW;
    localparam int F_OP_LO  = F_DST_LO + 2;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ALU  = 3'd1,
        OP_MOV  = 3'd2,
        OP_HALT = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        DST_BANK = 2'd0,
        DST_RQ   = 2'd1,
        DST_RD   = 2'd2,
        DST_NONE = 2'd3
    } dst_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_DONE
    } state_e;

    // One-hot {rd_we, rq_we, write} for a destination; DST_NONE writes nothing.
    function automatic logic [2:0] dst_we(dst_e d);
        case (d)
            DST_BANK: return 3'b001;
            DST_RQ:   return 3'b010;
            DST_RD:   return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/kf_instr_decode.sv
// Combinational split of a micro-instruction into op, destination, bank
// addresses, ALU function and an illegal-opcode flag.
module kf_instr_decode
    import kf_pkg::*;
#(
    parameter int ADDRW = KF_ADDRW,
    parameter int FNW   = KF_FNW,
    parameter int INSTW = KF_INSTW
) (
    input  logic [INSTW-1:0] instr_i,
    output op_e              op_o,
    output dst_e             dst_o,
    output logic [ADDRW-1:0] dira_o,
    output logic [ADDRW-1:0] dirb_o,
    output logic [FNW-1:0]   fn_o,
    output logic             illegal_o
);

    // Opcodes 4..7 all have the top bit set; the low bits then carry no meaning.
    assign illegal_o = instr_i[F_OP_LO+2];
    assign op_o      = op_e'({1'b0, instr_i[F_OP_LO +: 2]});
    assign dst_o     = dst_e'(instr_i[F_DST_LO +: 2]);
    assign dira_o    = instr_i[F_A_LO +: ADDRW];
    assign dirb_o    = instr_i[F_B_LO +: ADDRW];
    assign fn_o      = instr_i[F_FN_LO +: FNW];

endmodule

// File: rtl/kf_sequencer.sv
// Microprogram sequencer: fetches from an external ROM, launches ALU ops,
// drives bank addresses and exactly one write enable per writeback.
module kf_sequencer
    import kf_pkg::*;
#(
    parameter int ADDRW   = KF_ADDRW,
    parameter int PCW     = KF_PCW,
    parameter int FNW     = KF_FNW,
    parameter int INSTW   = KF_INSTW,
    parameter int MAXWAIT = KF_MAXWAIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PCW-1:0]   pc,
    input  logic [INSTW-1:0] instr,
    output logic             alu_start,
    output logic [FNW-1:0]   alu_fn,
    input  logic             alu_done,
    output logic             route_sel,
    output logic [ADDRW-1:0] dira,
    output logic [ADDRW-1:0] dirb,
    output logic             write,
    output logic             rq_we,
    output logic             rd_we,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WCW = $clog2(MAXWAIT + 1);

    state_e           state_q;
    op_e              op_q;
    dst_e             dst_q;
    logic             ill_q;
    logic [WCW-1:0]   wait_q;
    logic [PCW-1:0]   pc_q;
    logic [ADDRW-1:0] dira_q, dirb_q;
    logic [FNW-1:0]   alu_fn_q;
    logic             alu_start_q, route_sel_q, write_q, rq_we_q, rd_we_q;
    logic             busy_q, done_q, err_q;

    op_e              dec_op;
    dst_e             dec_dst;
    logic [ADDRW-1:0] dec_a, dec_b;
    logic [FNW-1:0]   dec_fn;
    logic             dec_ill;

    kf_instr_decode #(.ADDRW(ADDRW), .FNW(FNW), .INSTW(INSTW)) u_dec (
        .instr_i   (instr),
        .op_o      (dec_op),
        .dst_o     (dec_dst),
        .dira_o    (dec_a),
        .dirb_o    (dec_b),
        .fn_o      (dec_fn),
        .illegal_o (dec_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            dst_q       <= DST_BANK;
            ill_q       <= 1'b0;
            wait_q      <= '0;
            pc_q        <= '0;
            dira_q      <= '0;
            dirb_q      <= '0;
            alu_fn_q    <= '0;
            alu_start_q <= 1'b0;
            route_sel_q <= 1'b0;
            write_q     <= 1'b0;
            rq_we_q     <= 1'b0;
            rd_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alu_start_q <= 1'b0;
            done_q      <= 1'b0;
            write_q     <= 1'b0;
            rq_we_q     <= 1'b0;
            rd_we_q     <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                    S_FETCH: begin
                        op_q     <= dec_op;
                        dst_q    <= dec_dst;
                        ill_q    <= dec_ill;
                        dira_q   <= dec_a;
                        dirb_q   <= dec_b;
                        alu_fn_q <= dec_fn;
                        state_q  <= S_ISSUE;
                    end
                    S_ISSUE: if (ill_q) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        case (op_q)
                            OP_NOP: if (pc_q == '1) begin
                                err_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                pc_q    <= pc_q + 1'b1;
                                state_q <= S_FETCH;
                            end
                            OP_ALU: begin
                                alu_start_q <= 1'b1;
                                wait_q      <= '0;
                                state_q     <= S_WAIT;
                            end
                            OP_MOV: begin
                                route_sel_q <= 1'b1;
                                {rd_we_q, rq_we_q, write_q} <= dst_we(dst_q);
                                state_q     <= S_WB;
                            end
                            default: begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                    S_WAIT: if (alu_done) begin
                        route_sel_q <= 1'b0;
                        {rd_we_q, rq_we_q, write_q} <= dst_we(dst_q);
                        state_q     <= S_WB;
                    end else if (wait_q == WCW'(MAXWAIT - 1)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                    // The enable pulse is live during this cycle; only advance here.
                    S_WB: if (pc_q == '1) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_FETCH;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pc        = pc_q;
    assign alu_start = alu_start_q;
    assign alu_fn    = alu_fn_q;
    assign route_sel = route_sel_q;
    assign dira      = dira_q;
    assign dirb      = dirb_q;
    assign write     = write_q;
    assign rq_we     = rq_we_q;
    assign rd_we     = rd_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_kf_sequencer.sv
// Scenario bench for kf_sequencer: ROM array, ALU responder, event monitor,
// and a latency/writeback model derived from per-instruction rules.
module tb_kf_sequencer;
    import kf_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, alu_done = 1'b0;
    logic [7:0]  pc;
    logic [17:0] instr;
    logic        alu_start, route_sel, write, rq_we, rd_we, busy, done, err;
    logic [2:0]  alu_fn;
    logic [4:0]  dira, dirb;

    logic [17:0] rom [256];
    int          alu_dly [256];
    bit          resp_en = 1'b1;
    int          resp_d;
    int          total = 0, bad = 0;

    bit          mon_en = 1'b0, pc_left0;
    int          n_start, n_wr, n_rq, n_rd, n_done, n_multi, n_pcret;
    logic [12:0] ev_q [$];
    logic [12:0] alu_q [$];

    always #5 clk = ~clk;
    assign instr = rom[pc];

    kf_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pc(pc), .instr(instr),
        .alu_start(alu_start), .alu_fn(alu_fn), .alu_done(alu_done), .route_sel(route_sel),
        .dira(dira), .dirb(dirb), .write(write), .rq_we(rq_we), .rd_we(rd_we),
        .busy(busy), .done(done), .err(err)
    );

    // ALU model: alu_done lands in WAIT cycle index alu_dly[pc].
    always begin
        @(negedge clk);
        if (alu_start === 1'b1 && resp_en) begin
            resp_d = alu_dly[pc];
            repeat (resp_d) @(negedge clk);
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
        end
    end

    always @(negedge clk) if (mon_en) begin
        if (alu_start) begin n_start++; alu_q.push_back({alu_fn, dira, dirb}); end
        if (write) begin n_wr++; ev_q.push_back({2'd0, route_sel, dira, dirb}); end
        if (rq_we) begin n_rq++; ev_q.push_back({2'd1, route_sel, dira, dirb}); end
        if (rd_we) begin n_rd++; ev_q.push_back({2'd2, route_sel, dira, dirb}); end
        if (int'(write) + int'(rq_we) + int'(rd_we) > 1) n_multi++;
        if (done) n_done++;
        if (busy && pc != 8'd0) pc_left0 = 1'b1;
        if (busy && pc == 8'd0 && pc_left0) n_pcret++;
    end

    function automatic logic [17:0] mk(int op, int dst, int a, int b, int fn);
        logic [17:0] r;
        r = {3'(op), 2'(dst), 5'(a), 5'(b), 3'(fn)};
        return r;
    endfunction

    task automatic mon_clear();
        n_start = 0; n_wr = 0; n_rq = 0; n_rd = 0; n_done = 0; n_multi = 0; n_pcret = 0;
        pc_left0 = 1'b0;
        ev_q.delete(); alu_q.delete();
        mon_en = 1'b1;
    endtask

    // Start a program, optionally re-pulse start at cycle restart_at, wait for done.
    task automatic run(input int bound, input int restart_at, output int cyc,
                       output logic [7:0] pc_d, output logic err_d, output logic busy_a);
        mon_clear();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < bound) begin
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pc_d = pc; err_d = err;
        @(negedge clk);
        busy_a = busy;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({pc, alu_start, alu_fn, route_sel, dira, dirb, write, rq_we, rd_we, busy, done, err} !== '0) begin
            bad++; $display("FAIL reset_outputs: pc=%0d busy=%b err=%b done=%b, required all zero", pc, busy, err, done);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_alu_basic();
        int cyc; logic [7:0] p; logic e, b;
        rom[0] = mk(1, 0, 5, 7, 2); rom[1] = mk(3, 3, 0, 0, 0); alu_dly[0] = 2;
        run(100, 0, cyc, p, e, b);
        total++; if (cyc !== 9) begin bad++; $display("FAIL alu_latency: got %0d cycles, required 9", cyc); end
        total++; if (n_start !== 1 || alu_q.size() != 1) begin bad++; $display("FAIL alu_start_count: got %0d, required 1", n_start); end
        else begin
            total++; if (alu_q[0] !== {3'd2, 5'd5, 5'd7}) begin bad++; $display("FAIL alu_fields: got %h, required %h", alu_q[0], {3'd2, 5'd5, 5'd7}); end
        end
        total++; if (n_wr !== 1 || n_rq + n_rd != 0 || ev_q.size() != 1) begin bad++; $display("FAIL alu_we_count: write=%0d rq=%0d rd=%0d, required 1/0/0", n_wr, n_rq, n_rd); end
        else begin
            total++; if (ev_q[0] !== {2'd0, 1'b0, 5'd5, 5'd7}) begin bad++; $display("FAIL alu_wb_fields: got %h, required %h", ev_q[0], {2'd0, 1'b0, 5'd5, 5'd7}); end
        end
        total++; if (p !== 8'd1 || e !== 1'b0) begin bad++; $display("FAIL alu_end_pc: pc=%0d err=%b, required pc=1 err=0", p, e); end
    endtask

    task automatic test_mov_prog();
        int cyc; logic [7:0] p; logic e, b;
        rom[0] = mk(2, 1, 3, 0, 0); rom[1] = mk(2, 2, 4, 0, 0); rom[2] = mk(3, 0, 0, 0, 0);
        run(100, 0, cyc, p, e, b);
        total++; if (cyc !== 9) begin bad++; $display("FAIL mov_latency: got %0d cycles, required 9", cyc); end
        total++; if (ev_q.size() != 2 || n_wr != 0 || n_rq != 1 || n_rd != 1) begin bad++; $display("FAIL mov_we_count: write=%0d rq=%0d rd=%0d, required 0/1/1", n_wr, n_rq, n_rd); end
        else begin
            total++; if (ev_q[0] !== {2'd1, 1'b1, 5'd3, 5'd0} || ev_q[1] !== {2'd2, 1'b1, 5'd4, 5'd0}) begin
                bad++; $display("FAIL mov_events: got %h %h, required %h %h", ev_q[0], ev_q[1], {2'd1, 1'b1, 5'd3, 5'd0}, {2'd2, 1'b1, 5'd4, 5'd0}); end
        end
        total++; if (p !== 8'd2 || n_done !== 1 || b !== 1'b0) begin bad++; $display("FAIL mov_end: pc=%0d done_pulses=%0d busy_after=%b, required 2/1/0", p, n_done, b); end
    endtask

    task automatic test_timeout();
        int cyc; logic [7:0] p; logic e, b;
        resp_en = 1'b0;
        rom[0] = mk(1, 0, 1, 2, 3); rom[1] = mk(3, 0, 0, 0, 0);
        run(200, 0, cyc, p, e, b);
        resp_en = 1'b1;
        total++; if (cyc !== 67) begin bad++; $display("FAIL timeout_latency: got %0d cycles, required 67", cyc); end
        total++; if (e !== 1'b1 || n_done !== 1) begin bad++; $display("FAIL timeout_err: err=%b done_pulses=%0d, required 1/1", e, n_done); end
        total++; if (n_wr + n_rq + n_rd != 0) begin bad++; $display("FAIL timeout_no_we: got %0d enables, required 0", n_wr + n_rq + n_rd); end
    endtask

    task automatic test_abort();
        int cyc, k; logic [7:0] p; logic e, b;
        rom[0] = mk(1, 0, 6, 8, 1); rom[1] = mk(3, 0, 0, 0, 0); alu_dly[0] = 1;
        mon_clear();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (alu_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL abort_reach_wait: alu_start=%b, required 1", alu_start); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0 || n_done !== 0 || n_wr + n_rq + n_rd != 0 || err !== 1'b0) begin
            bad++; $display("FAIL abort_idle: busy=%b done_pulses=%0d enables=%0d err=%b, required 0/0/0/0", busy, n_done, n_wr + n_rq + n_rd, err); end
        run(100, 0, cyc, p, e, b);
        total++; if (cyc !== 8 || p !== 8'd1 || n_wr !== 1) begin bad++; $display("FAIL abort_restart: cycles=%0d pc=%0d writes=%0d, required 8/1/1", cyc, p, n_wr); end
    endtask

    task automatic test_illegal_start_reset();
        int cyc, k; logic [7:0] p; logic e, b;
        rom[0] = mk(5, 0, 0, 0, 0);
        run(50, 0, cyc, p, e, b);
        total++; if (cyc !== 3 || e !== 1'b1 || n_done !== 1) begin bad++; $display("FAIL illegal_op: cycles=%0d err=%b done_pulses=%0d, required 3/1/1", cyc, e, n_done); end
        for (int i = 0; i < 3; i++) rom[i] = mk(0, 0, 0, 0, 0);
        rom[3] = mk(3, 0, 0, 0, 0);
        run(100, 3, cyc, p, e, b);
        total++; if (cyc !== 9 || p !== 8'd3 || e !== 1'b0) begin bad++; $display("FAIL start_while_busy: cycles=%0d pc=%0d err=%b, required 9/3/0", cyc, p, e); end
        rom[0] = mk(2, 0, 9, 0, 0); rom[1] = mk(3, 0, 0, 0, 0);
        mon_clear();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (write !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        total++; if (write !== 1'b1) begin bad++; $display("FAIL reset_reach_wb: write=%b, required 1", write); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({pc, alu_start, alu_fn, route_sel, dira, dirb, write, rq_we, rd_we, busy, done, err} !== '0) begin
            bad++; $display("FAIL reset_async_wb: pc=%0d write=%b busy=%b route_sel=%b, required all zero", pc, write, busy, route_sel); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_pc_wrap();
        int cyc; logic [7:0] p; logic e, b;
        for (int i = 0; i < 256; i++) rom[i] = mk(0, 0, 0, 0, 0);
        run(700, 0, cyc, p, e, b);
        total++; if (cyc !== 513 || p !== 8'd255) begin bad++; $display("FAIL wrap_end: cycles=%0d pc=%0d, required 513/255", cyc, p); end
        total++; if (e !== 1'b1 || n_done !== 1 || n_pcret !== 0) begin bad++; $display("FAIL wrap_err: err=%b done_pulses=%0d pc_returns=%0d, required 1/1/0", e, n_done, n_pcret); end
    endtask

    task automatic test_random();
        int cyc, len, op, dst, a, bb, fn, exp_cyc; logic [7:0] p; logic e, b;
        logic [12:0] exp_ev [$];
        logic [12:0] exp_alu [$];
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, 8);
            exp_cyc = 3;
            exp_ev.delete(); exp_alu.delete();
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 2); dst = $urandom_range(0, 3);
                a = $urandom_range(0, 31); bb = $urandom_range(0, 31); fn = $urandom_range(0, 7);
                alu_dly[i] = $urandom_range(0, 5);
                rom[i] = mk(op, dst, a, bb, fn);
                exp_cyc += (op == 0) ? 2 : (op == 2) ? 3 : 4 + alu_dly[i];
                if (op == 1) exp_alu.push_back({3'(fn), 5'(a), 5'(bb)});
                if (op != 0 && dst != 3) exp_ev.push_back({2'(dst), (op == 2), 5'(a), 5'(bb)});
            end
            rom[len] = mk(3, 0, 0, 0, 0);
            run(200, 0, cyc, p, e, b);
            total++; if (cyc !== exp_cyc || p !== 8'(len) || e !== 1'b0) begin
                bad++; $display("FAIL rand_run%0d: cycles=%0d pc=%0d err=%b, required %0d/%0d/0", it, cyc, p, e, exp_cyc, len); end
            total++; if (ev_q.size() != exp_ev.size() || alu_q.size() != exp_alu.size() || n_multi != 0) begin
                bad++; $display("FAIL rand_counts%0d: wb=%0d alu=%0d multi=%0d, required %0d/%0d/0", it, ev_q.size(), alu_q.size(), n_multi, exp_ev.size(), exp_alu.size()); end
            else begin
                foreach (exp_ev[i]) begin
                    total++; if (ev_q[i] !== exp_ev[i]) begin bad++; $display("FAIL rand_wb%0d_%0d: got %h, required %h", it, i, ev_q[i], exp_ev[i]); end
                end
                foreach (exp_alu[i]) begin
                    total++; if (alu_q[i] !== exp_alu[i]) begin bad++; $display("FAIL rand_alu%0d_%0d: got %h, required %h", it, i, alu_q[i], exp_alu[i]); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin rom[i] = '0; alu_dly[i] = 0; end
        test_reset();
        test_alu_basic();
        test_mov_prog();
        test_timeout();
        test_abort();
        test_illegal_start_reset();
        test_pc_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
